sea_round_sched: RTL and testbench
==================================

Name: sea_round_sched

Overview:
Two-requester scheduler that shares one single-round SEA datapath (48-bit L/R/K halves) between an encrypt client and a decrypt client.
- Arbitrates between the clients and latches the winner's operands.
- Iterates the external round function NR times, updating L, R and K each cycle.
- Sequences the key-schedule swap at mid-point.
- Returns the result with a direction tag over a valid/ready handshake.

Parameters:
NB, 48, half-block / key width in bits
NR, 84, round count; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
enc_valid  in  1  encrypt request
enc_ready  out  1  encrypt request accepted this cycle
enc_l / enc_r / enc_k  in  NB each  encrypt operands
dec_valid  in  1  decrypt request
dec_ready  out  1  decrypt request accepted this cycle
dec_l / dec_r / dec_k  in  NB each  decrypt operands
rnd_l / rnd_r / rnd_k  out  NB each  current state to datapath
rnd_dir  out  1  0 = encrypt, 1 = decrypt
rnd_ksw  out  1  key-swap round indicator to datapath
rnd_nl / rnd_nr / rnd_nk  in  NB each  datapath next state (combinational from rnd_*)
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_l / out_r  out  NB each  result halves
out_tag  out  1  0 = encrypt result, 1 = decrypt result
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State goes to IDLE; round counter = 0.
  - L/R/K registers, out_l, out_r, out_tag, rnd_dir = 0.
  - out_valid = 0.
  - last_grant = dec, so encrypt wins the first tie.
  - rst dominates every other input, including mid-run and during DONE: the operation is dropped and no result is emitted.
- FSM IDLE:
  - enc_ready/dec_ready are combinational: high only for the granted requester, and only when its valid is high.
  - Grant rule: if only one client is valid it wins. If both are valid, the requester not equal to last_grant wins.
  - On grant, the edge loads L/R/K from the winner's operands, sets rnd_dir = winner, round = 0, last_grant = winner, and moves to RUN.
  - No grant while not in IDLE; enc_ready and dec_ready are 0 in RUN and DONE.
- FSM RUN:
  - rnd_l/r/k = L/R/K registers.
  - Each edge: L <= rnd_nl, R <= rnd_nr, K <= rnd_nk, round <= round + 1.
  - rnd_ksw = 1 exactly when round == NR/2, else 0.
  - On the edge where round == NR-1, move to DONE.
  - Round counter width is $clog2(NR); it never wraps within an operation.
- FSM DONE:
  - out_valid = 1; out_l = L, out_r = R, out_tag = rnd_dir, all held stable.
  - On out_valid && out_ready the edge moves to IDLE and out_valid drops the next cycle.
  - Backpressure is unlimited; the state stays DONE.
- Latency: handshake at edge T gives out_valid high in the cycle after edge T+NR, i.e. NR+1 cycles from the request cycle.
- Throughput: one operation per NR+2 cycles minimum, because IDLE costs one cycle.
- A new request presented during the out_valid/out_ready cycle is not accepted until the following IDLE cycle.
- rnd_* outputs are don't-care outside RUN but are driven from the registers (no X).
- busy = 1 in RUN and DONE.

Optional Feature:
SEA_FAIR_RR_EN
- Defined: round-robin tie-break between the clients, as described above.
- Undefined: fixed priority, encrypt always wins when both are valid. The last_grant register is removed.

Decomposition:
- Package sea_pkg:
  - SEA_NB = 48, SEA_NR_DEFAULT = 84.
  - State enum {IDLE, RUN, DONE}.
  - Tag constants TAG_ENC = 0, TAG_DEC = 1.
- Sub-module sea_arb2: the 2-way arbiter.
  - Inputs: valids, enable, last_grant.
  - Outputs: one-hot grant.
  - The macro lives here.

Test Plan:
- Reset then single encrypt: NR = 4, bench datapath nl = r, nr = l ^ k, nk = k + 1; enc_l = 1, enc_r = 2, enc_k = 3. Required: enc_ready for 1 cycle, out_valid 5 cycles later, out_tag = 0, out_l/out_r equal a 4-round software model.
- rnd_ksw: NR = 84. Required: exactly one pulse, in the RUN cycle with round = 42.
- Simultaneous requests, SEA_FAIR_RR_EN defined, enc and dec held valid. Required: tags alternate 0,1,0,1 across four results. Undefined: tags 0,0,0,0.
- Backpressure: out_ready held low 10 cycles. Required: out_valid and outputs stable, no ready to either client, busy = 1.
- Reset mid-run (round = 2, NR = 4). Required: next cycle busy = 0, out_valid = 0; a subsequent request completes correctly.
- Back-to-back: out_ready = 1 while dec_valid = 1. Required: dec_ready asserted exactly one cycle after out_valid falls, i.e. NR+2 cycles between grants.

Source files
------------

// File: rtl/sea_pkg.sv
// Shared types and constants for the SEA round scheduler.
package sea_pkg;

    localparam int SEA_NB         = 48;
    localparam int SEA_NR_DEFAULT = 84;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tags double as requester indices in the {dec, enc} valid/grant vectors.
    localparam logic TAG_ENC = 1'b0;
    localparam logic TAG_DEC = 1'b1;

endpackage

// File: rtl/sea_arb2.sv
// Two-way arbiter for the encrypt/decrypt clients; bit 0 = encrypt, bit 1 = decrypt.
// SEA_FAIR_RR_EN selects round-robin tie-break; otherwise encrypt has fixed priority.
module sea_arb2
    import sea_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       en_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
`ifdef SEA_FAIR_RR_EN
                // On a tie the client that did not win last time goes first.
                grant_o = (last_grant_i == TAG_DEC) ? 2'b01 : 2'b10;
`else
                grant_o = 2'b01;
`endif
            end else begin
                grant_o = valid_i;
            end
        end
    end

`ifndef SEA_FAIR_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/sea_round_sched.sv
// Shares one single-round SEA datapath between an encrypt and a decrypt client.
// Optional SEA_FAIR_RR_EN (in sea_arb2) enables round-robin tie-break and the last-grant register.
module sea_round_sched
    import sea_pkg::*;
#(
    parameter int NB = SEA_NB,
    parameter int NR = SEA_NR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enc_valid,
    output logic          enc_ready,
    input  logic [NB-1:0] enc_l,
    input  logic [NB-1:0] enc_r,
    input  logic [NB-1:0] enc_k,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [NB-1:0] dec_l,
    input  logic [NB-1:0] dec_r,
    input  logic [NB-1:0] dec_k,
    output logic [NB-1:0] rnd_l,
    output logic [NB-1:0] rnd_r,
    output logic [NB-1:0] rnd_k,
    output logic          rnd_dir,
    output logic          rnd_ksw,
    input  logic [NB-1:0] rnd_nl,
    input  logic [NB-1:0] rnd_nr,
    input  logic [NB-1:0] rnd_nk,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NB-1:0] out_l,
    output logic [NB-1:0] out_r,
    output logic          out_tag,
    output logic          busy,
    output state_t        dbg_state
);

    localparam int CW = (NR > 1) ? $clog2(NR) : 1;

    generate
        if ((NR % 2) != 0 || NR < 2) begin : g_bad_nr
            $error("sea_round_sched: NR must be even and >= 2");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Client readies are combinational from the arbiter and only assert in IDLE;
    // out_valid holds its data stable until out_ready is seen.

    state_t          state_q, state_d;
    logic [CW-1:0]   round_q, round_d;
    logic [NB-1:0]   l_q, l_d, r_q, r_d, k_q, k_d;
    logic            dir_q, dir_d;
    logic            last_grant;
    logic [1:0]      grant;

`ifdef SEA_FAIR_RR_EN
    logic            last_q, last_d;
    assign last_grant = last_q;
`else
    assign last_grant = TAG_DEC;
`endif

    sea_arb2 u_arb (
        .valid_i      ({dec_valid, enc_valid}),
        .en_i         (state_q == IDLE),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        l_d     = l_q;
        r_d     = r_q;
        k_d     = k_q;
        dir_d   = dir_q;
`ifdef SEA_FAIR_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant[TAG_ENC] || grant[TAG_DEC]) begin
                    l_d     = grant[TAG_DEC] ? dec_l : enc_l;
                    r_d     = grant[TAG_DEC] ? dec_r : enc_r;
                    k_d     = grant[TAG_DEC] ? dec_k : enc_k;
                    dir_d   = grant[TAG_DEC] ? TAG_DEC : TAG_ENC;
                    round_d = '0;
`ifdef SEA_FAIR_RR_EN
                    last_d  = grant[TAG_DEC] ? TAG_DEC : TAG_ENC;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d = rnd_nl;
                r_d = rnd_nr;
                k_d = rnd_nk;
                if (round_q == CW'(NR - 1)) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            l_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            dir_q   <= TAG_ENC;
`ifdef SEA_FAIR_RR_EN
            last_q  <= TAG_DEC;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            l_q     <= l_d;
            r_q     <= r_d;
            k_q     <= k_d;
            dir_q   <= dir_d;
`ifdef SEA_FAIR_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign enc_ready = grant[TAG_ENC];
    assign dec_ready = grant[TAG_DEC];
    assign rnd_l     = l_q;
    assign rnd_r     = r_q;
    assign rnd_k     = k_q;
    assign rnd_dir   = dir_q;
    assign rnd_ksw   = (state_q == RUN) && (round_q == CW'(NR / 2));
    assign out_valid = (state_q == DONE);
    assign out_l     = l_q;
    assign out_r     = r_q;
    assign out_tag   = dir_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sea_round_sched.sv
// Self-checking bench for sea_round_sched: NR=4 instance with a cycle-level reference model,
// plus an NR=84 instance for the key-swap pulse and long-run result.
module tb_sea_round_sched;
    import sea_pkg::*;

    localparam int NB   = 48;
    localparam int NR   = 4;
    localparam int NR_L = 84;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- NR=4 instance ----------------
    logic          rst = 1'b1;
    logic          enc_valid = 1'b0, dec_valid = 1'b0, out_ready = 1'b0;
    logic [NB-1:0] enc_l = '0, enc_r = '0, enc_k = '0;
    logic [NB-1:0] dec_l = '0, dec_r = '0, dec_k = '0;
    logic          enc_ready, dec_ready, rnd_dir, rnd_ksw, out_valid, out_tag, busy;
    logic [NB-1:0] rnd_l, rnd_r, rnd_k, rnd_nl, rnd_nr, rnd_nk, out_l, out_r;
    state_t        dbg_state;

    assign rnd_nl = rnd_r;
    assign rnd_nr = rnd_l ^ rnd_k;
    assign rnd_nk = rnd_k + 1'b1;

    sea_round_sched #(.NB(NB), .NR(NR)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_l(enc_l), .enc_r(enc_r), .enc_k(enc_k),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_l(dec_l), .dec_r(dec_r), .dec_k(dec_k),
        .rnd_l(rnd_l), .rnd_r(rnd_r), .rnd_k(rnd_k), .rnd_dir(rnd_dir), .rnd_ksw(rnd_ksw),
        .rnd_nl(rnd_nl), .rnd_nr(rnd_nr), .rnd_nk(rnd_nk),
        .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
        .out_tag(out_tag), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- NR=84 instance ----------------
    logic          b_rst = 1'b1;
    logic          b_enc_valid = 1'b0, b_dec_valid = 1'b0, b_out_ready = 1'b0;
    logic [NB-1:0] b_enc_l = '0, b_enc_r = '0, b_enc_k = '0;
    logic [NB-1:0] b_dec_l = '0, b_dec_r = '0, b_dec_k = '0;
    logic          b_enc_ready, b_dec_ready, b_rnd_dir, b_rnd_ksw, b_out_valid, b_out_tag, b_busy;
    logic [NB-1:0] b_rnd_l, b_rnd_r, b_rnd_k, b_rnd_nl, b_rnd_nr, b_rnd_nk, b_out_l, b_out_r;
    state_t        b_dbg_state;

    assign b_rnd_nl = b_rnd_r;
    assign b_rnd_nr = b_rnd_l ^ b_rnd_k;
    assign b_rnd_nk = b_rnd_k + 1'b1;

    sea_round_sched #(.NB(NB), .NR(NR_L)) dut84 (
        .clk(clk), .rst(b_rst),
        .enc_valid(b_enc_valid), .enc_ready(b_enc_ready), .enc_l(b_enc_l), .enc_r(b_enc_r), .enc_k(b_enc_k),
        .dec_valid(b_dec_valid), .dec_ready(b_dec_ready), .dec_l(b_dec_l), .dec_r(b_dec_r), .dec_k(b_dec_k),
        .rnd_l(b_rnd_l), .rnd_r(b_rnd_r), .rnd_k(b_rnd_k), .rnd_dir(b_rnd_dir), .rnd_ksw(b_rnd_ksw),
        .rnd_nl(b_rnd_nl), .rnd_nr(b_rnd_nr), .rnd_nk(b_rnd_nk),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_l(b_out_l), .out_r(b_out_r),
        .out_tag(b_out_tag), .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n applications of the bench round function: L'=R, R'=L^K, K'=K+1.
    function automatic logic [3*NB-1:0] sea_model(input logic [NB-1:0] l, input logic [NB-1:0] r,
                                                  input logic [NB-1:0] k, input int n);
        logic [NB-1:0] t;
        for (int i = 0; i < n; i++) begin
            t = l;
            l = r;
            r = t ^ k;
            k = k + 1'b1;
        end
        return {l, r, k};
    endfunction

    // ---------------- reference model + scoreboard (NR=4 instance) ----------------
    logic [2*NB:0] exp_q[$];        // {tag, out_l, out_r}
    logic          tag_log[$];      // tags of completed results, in order
    int            grant_cyc[$];    // cycle numbers of grants
    int            cyc = 0;
    bit            m_on = 1'b0;
    int            m_phase = 0;     // 0 idle, 1 running, 2 result waiting
    int            m_cnt = 0;       // rounds completed so far in the current op
    logic          m_last = 1'b1;
    logic          m_tag = 1'b0;
    bit            m_first = 1'b0;
    logic [1:0]    m_g;
    logic [3*NB-1:0] m_res;

    always @(negedge clk) begin
        cyc++;
        m_g = 2'b00;
        if (enc_valid && dec_valid) begin
`ifdef SEA_FAIR_RR_EN
            m_g = (m_last == 1'b1) ? 2'b01 : 2'b10;
`else
            m_g = 2'b01;
`endif
        end else begin
            m_g = {dec_valid, enc_valid};
        end
        if (m_on) begin
            case (m_phase)
                0: begin
                    if (!rst) begin
                        check_eq("idle_enc_ready", 64'(enc_ready), 64'(m_g[0]));
                        check_eq("idle_dec_ready", 64'(dec_ready), 64'(m_g[1]));
                    end
                    check_eq("idle_busy", 64'(busy), 64'd0);
                    check_eq("idle_out_valid", 64'(out_valid), 64'd0);
                end
                1: begin
                    check_eq("run_busy", 64'(busy), 64'd1);
                    check_eq("run_out_valid", 64'(out_valid), 64'd0);
                    check_eq("run_ready", 64'({dec_ready, enc_ready}), 64'd0);
                    check_eq("run_ksw", 64'(rnd_ksw), 64'(m_cnt == NR / 2));
                    check_eq("run_dir", 64'(rnd_dir), 64'(m_tag));
                end
                default: begin
                    check_eq("done_out_valid", 64'(out_valid), 64'd1);
                    check_eq("done_busy", 64'(busy), 64'd1);
                    check_eq("done_ready", 64'({dec_ready, enc_ready}), 64'd0);
                    if (m_first) begin
                        check_eq("latency", 64'(cyc - grant_cyc[$]), 64'(NR + 1));
                        m_first = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        check_eq("sb_empty", 64'd0, 64'd1);
                    end else begin
                        check_eq("out_tag", 64'(out_tag), 64'(exp_q[0][2*NB]));
                        check_eq("out_l", 64'(out_l), 64'(exp_q[0][2*NB-1:NB]));
                        check_eq("out_r", 64'(out_r), 64'(exp_q[0][NB-1:0]));
                    end
                end
            endcase
        end
        if (rst) begin
            m_on    = 1'b1;
            m_phase = 0;
            m_last  = 1'b1;
            m_first = 1'b0;
            exp_q.delete();
        end else if (m_on) begin
            case (m_phase)
                0: if (m_g != 2'b00) begin
                    m_tag  = m_g[1];
                    m_last = m_g[1];
                    m_res  = m_g[1] ? sea_model(dec_l, dec_r, dec_k, NR) : sea_model(enc_l, enc_r, enc_k, NR);
                    exp_q.push_back({m_tag, m_res[3*NB-1:2*NB], m_res[2*NB-1:NB]});
                    grant_cyc.push_back(cyc);
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: if (m_cnt == NR - 1) begin
                    m_phase = 2;
                    m_first = 1'b1;
                end else begin
                    m_cnt++;
                end
                default: if (out_ready) begin
                    tag_log.push_back(m_tag);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) return;
            step();
        end
        check_eq(tag, 64'd1, 64'd0);
    endtask

    task automatic wait_grants(input string tag, input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (grant_cyc.size() >= n) return;
            step();
        end
        check_eq(tag, 64'(grant_cyc.size()), 64'(n));
    endtask

    function automatic logic [NB-1:0] rnd48();
        return NB'({$urandom(), $urandom()});
    endfunction

    logic [NB-1:0]   hold_l, hold_r;
    logic [3*NB-1:0] ref_res;
    logic [NB-1:0]   sl, sr, sk;
    int              nt, ng, ksw_cnt, ksw_pos, lat;
    bit              seen;

    initial begin
        // Reset and reset values
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_l", 64'(out_l), 64'd0);
        check_eq("rst_out_r", 64'(out_r), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_rnd_dir", 64'(rnd_dir), 64'd0);
        check_eq("rst_rnd_k", 64'(rnd_k), 64'd0);

        // Single encrypt 1/2/3 over 4 rounds -> L=7, R=0
        step();
        enc_valid = 1'b1; enc_l = 48'd1; enc_r = 48'd2; enc_k = 48'd3;
        out_ready = 1'b1;
        step();
        enc_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check_eq("t1_out_l", 64'(out_l), 64'd7);
                check_eq("t1_out_r", 64'(out_r), 64'd0);
                check_eq("t1_out_tag", 64'(out_tag), 64'd0);
            end
        end
        check_eq("t1_seen", 64'(seen), 64'd1);
        step();
        wait_idle("t1_idle_timeout", 10);

        // Key-swap pulse on the NR=84 instance
        step();
        b_rst = 1'b0;
        sl = rnd48(); sr = rnd48(); sk = rnd48();
        b_enc_l = sl; b_enc_r = sr; b_enc_k = sk; b_enc_valid = 1'b1;
        @(negedge clk);
        check_eq("ksw_grant", 64'(b_enc_ready), 64'd1);
        step();
        b_enc_valid = 1'b0;
        ksw_cnt = 0; ksw_pos = -1; lat = 0; seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                seen = 1'b1;
                lat  = i;
            end else if (b_rnd_ksw) begin
                ksw_cnt++;
                ksw_pos = i - 1;
            end
        end
        ref_res = sea_model(sl, sr, sk, NR_L);
        check_eq("ksw_count", 64'(ksw_cnt), 64'd1);
        check_eq("ksw_round", 64'(ksw_pos), 64'(NR_L / 2));
        check_eq("nr84_latency", 64'(lat), 64'(NR_L + 1));
        check_eq("nr84_out_l", 64'(b_out_l), 64'(ref_res[3*NB-1:2*NB]));
        check_eq("nr84_out_r", 64'(b_out_r), 64'(ref_res[2*NB-1:NB]));
        check_eq("nr84_out_tag", 64'(b_out_tag), 64'd0);
        step();
        b_out_ready = 1'b1;
        step();
        step();
        check_eq("nr84_idle", 64'(b_busy), 64'd0);

        // Simultaneous requests from reset: tie-break pattern
        rst = 1'b1;
        step();
        rst = 1'b0;
        nt = tag_log.size();
        enc_valid = 1'b1; dec_valid = 1'b1;
        enc_l = rnd48(); enc_r = rnd48(); enc_k = rnd48();
        dec_l = rnd48(); dec_r = rnd48(); dec_k = rnd48();
        for (int i = 0; i < 60 && tag_log.size() < nt + 4; i++) step();
        enc_valid = 1'b0; dec_valid = 1'b0;
        check_eq("tie_count", 64'(tag_log.size() >= nt + 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (tag_log.size() > nt + i) begin
`ifdef SEA_FAIR_RR_EN
                check_eq("tie_tag", 64'(tag_log[nt+i]), 64'(i % 2));
`else
                check_eq("tie_tag", 64'(tag_log[nt+i]), 64'd0);
`endif
            end
        end
        wait_idle("tie_idle_timeout", 20);

        // Backpressure: out_ready low 10 cycles, both clients requesting meanwhile
        out_ready = 1'b0;
        step();
        enc_valid = 1'b1; enc_l = rnd48(); enc_r = rnd48(); enc_k = rnd48();
        step();
        enc_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check_eq("bp_seen", 64'(seen), 64'd1);
        hold_l = out_l; hold_r = out_r;
        step();
        enc_valid = 1'b1; dec_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_l", 64'(out_l), 64'(hold_l));
            check_eq("bp_r", 64'(out_r), 64'(hold_r));
            check_eq("bp_ready", 64'({dec_ready, enc_ready}), 64'd0);
            check_eq("bp_busy", 64'(busy), 64'd1);
            step();
        end
        enc_valid = 1'b0; dec_valid = 1'b0;
        out_ready = 1'b1;
        step();
        wait_idle("bp_idle_timeout", 10);

        // Reset in the round-2 cycle, then a decrypt completes
        enc_valid = 1'b1; enc_l = rnd48(); enc_r = rnd48(); enc_k = rnd48();
        @(negedge clk);
        check_eq("mr_grant", 64'(enc_ready), 64'd1);
        step();
        enc_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr_busy", 64'(busy), 64'd0);
        check_eq("mr_out_valid", 64'(out_valid), 64'd0);
        step();
        sl = rnd48(); sr = rnd48(); sk = rnd48();
        dec_valid = 1'b1; dec_l = sl; dec_r = sr; dec_k = sk;
        step();
        dec_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        ref_res = sea_model(sl, sr, sk, NR);
        check_eq("mr_seen", 64'(seen), 64'd1);
        check_eq("mr_out_l", 64'(out_l), 64'(ref_res[3*NB-1:2*NB]));
        check_eq("mr_out_r", 64'(out_r), 64'(ref_res[2*NB-1:NB]));
        check_eq("mr_out_tag", 64'(out_tag), 64'd1);
        step();
        wait_idle("mr_idle_timeout", 10);

        // Back-to-back decrypts: grants spaced NR+2 cycles
        ng = grant_cyc.size();
        dec_valid = 1'b1; dec_l = rnd48(); dec_r = rnd48(); dec_k = rnd48();
        wait_grants("b2b_timeout", ng + 3, 60);
        dec_valid = 1'b0;
        if (grant_cyc.size() >= ng + 3) begin
            check_eq("b2b_gap1", 64'(grant_cyc[ng+1] - grant_cyc[ng]), 64'(NR + 2));
            check_eq("b2b_gap2", 64'(grant_cyc[ng+2] - grant_cyc[ng+1]), 64'(NR + 2));
        end
        wait_idle("b2b_idle_timeout", 20);

        // Random traffic checked by the reference model
        for (int i = 0; i < 600; i++) begin
            enc_valid = 1'($urandom_range(0, 1));
            dec_valid = 1'($urandom_range(0, 1));
            enc_l = rnd48(); enc_r = rnd48(); enc_k = rnd48();
            dec_l = rnd48(); dec_r = rnd48(); dec_k = rnd48();
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; out_ready = 1'b1;
        step();
        wait_idle("rand_idle_timeout", 20);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
